// File: rtl/board_packet_forwarder_pkg.sv
// Shared constants and FSM state type for the board packet forwarder and its flit mux.
package board_packet_forwarder_pkg;

    localparam int NUM_BOARDS      = 8;
    localparam int SEL_WIDTH       = 4;
    localparam int DATA_WIDTH_DEF  = 256;

    localparam logic [SEL_WIDTH-1:0] SEL_INVALID = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_XFER     = 2'd2
    } fwd_state_t;

endpackage

// File: rtl/board_packet_forwarder_flit_mux.sv
// Combinational NUM_BOARDS:1 flit selector with one-hot ready return to the chosen board.
module board_flit_mux
    import board_packet_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                             i_en,
    input  logic [SEL_WIDTH-1:0]             i_sel,
    input  logic [NUM_BOARDS-1:0]            i_valid,
    input  logic [NUM_BOARDS-1:0]            i_last,
    input  logic [NUM_BOARDS*DATA_WIDTH-1:0] i_data,
    input  logic                             i_out_ready,
    output logic                             o_valid,
    output logic                             o_last,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [NUM_BOARDS-1:0]            o_in_ready
);

    logic w_sel_ok;

    // Select values 8..15 mean "no board"; everything stays quiet then.
    assign w_sel_ok = i_en & ~i_sel[SEL_WIDTH-1];

    always_comb begin
        o_valid    = 1'b0;
        o_last     = 1'b0;
        o_data     = '0;
        o_in_ready = '0;
        if (w_sel_ok) begin
            o_valid                 = i_valid[i_sel[2:0]];
            o_last                  = i_last[i_sel[2:0]];
            o_data                  = i_data[int'(i_sel[2:0])*DATA_WIDTH +: DATA_WIDTH];
            o_in_ready[i_sel[2:0]]  = i_out_ready;
        end
    end

endmodule

// File: rtl/board_packet_forwarder.sv
// Packet-granular forwarder behind the 8-board round-robin arbiter: arbitrate, latch winner,
// stream its flits to the tail (or MAX_FLITS truncation), count completed packets.
module board_packet_forwarder
    import board_packet_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_FLITS  = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_BOARDS-1:0]            i_in_valid,
    input  logic [NUM_BOARDS-1:0]            i_in_last,
    input  logic [NUM_BOARDS*DATA_WIDTH-1:0] i_in_data,
    output logic [NUM_BOARDS-1:0]            o_in_ready,
    output logic [NUM_BOARDS-1:0]            o_req_mask,
    output logic                             o_arb_enable,
    input  logic [SEL_WIDTH-1:0]             i_board_sel,
    output logic                             o_out_valid,
    output logic [DATA_WIDTH-1:0]            o_out_data,
    output logic                             o_out_last,
    output logic [SEL_WIDTH-1:0]             o_out_board,
    input  logic                             i_out_ready,
    output logic                             o_err_oversize,
    output logic [CNT_WIDTH-1:0]             o_pkt_count
);

    localparam int FCW = $clog2(MAX_FLITS) + 1;

    fwd_state_t           r_state;
    fwd_state_t           w_state_nxt;
    logic [SEL_WIDTH-1:0] r_sel_q;
    logic [FCW-1:0]       r_flit_cnt;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic                 r_err;

    logic                  w_xfer;
    logic                  w_arb_enable;
    logic                  w_mux_valid;
    logic                  w_mux_last;
    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_hs;
    logic                  w_at_max;
    logic                  w_end_pkt;
    logic                  w_trunc;
    logic                  w_grant_ok;

    assign w_xfer     = (r_state == ST_XFER);
    assign w_grant_ok = ~i_board_sel[SEL_WIDTH-1];

    board_flit_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .i_en        (w_xfer),
        .i_sel       (r_sel_q),
        .i_valid     (i_in_valid),
        .i_last      (i_in_last),
        .i_data      (i_in_data),
        .i_out_ready (i_out_ready),
        .o_valid     (w_mux_valid),
        .o_last      (w_mux_last),
        .o_data      (w_mux_data),
        .o_in_ready  (o_in_ready)
    );

    // r_flit_cnt counts completed handshakes, so the MAX_FLITS-th flit is on the bus at MAX_FLITS-1.
    assign w_at_max  = (r_flit_cnt == FCW'(MAX_FLITS - 1));
    assign w_hs      = w_mux_valid & i_out_ready;
    assign w_end_pkt = w_hs & (w_mux_last | w_at_max);
    assign w_trunc   = w_hs & w_at_max & ~w_mux_last;

    always_comb begin
        w_state_nxt  = r_state;
        w_arb_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_in_valid) begin
                    w_arb_enable = 1'b1;
                    w_state_nxt  = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                // No grant (empty set, or lone requester masked as last winner): just retry.
                w_state_nxt = w_grant_ok ? ST_XFER : ST_IDLE;
            end
            ST_XFER: begin
                if (w_end_pkt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sel_q     <= SEL_INVALID;
            r_flit_cnt  <= '0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_trunc;
            if (r_state == ST_WAIT_GNT) begin
                r_sel_q    <= w_grant_ok ? i_board_sel : SEL_INVALID;
                r_flit_cnt <= '0;
            end else if (w_hs) begin
                r_flit_cnt <= r_flit_cnt + FCW'(1);
            end
            if (w_end_pkt) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_req_mask     = i_in_valid;
    assign o_arb_enable   = w_arb_enable & ~i_rst;
    assign o_out_valid    = w_mux_valid;
    assign o_out_data     = w_mux_data;
    assign o_out_last     = w_mux_last | (w_mux_valid & w_at_max);
    assign o_out_board    = w_xfer ? r_sel_q : SEL_INVALID;
    assign o_err_oversize = r_err;
    assign o_pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_board_packet_forwarder.sv
// Bench for board_packet_forwarder: per-board flit sources, a round-robin arbiter model and a
// per-board expected-flit scoreboard derived from the packet/truncation rules.
module tb_board_packet_forwarder;

    localparam int DW   = 64;
    localparam int NB   = 8;
    localparam int MAXF = 64;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } flit_t;

    typedef struct {
        int            b;
        logic [DW-1:0] d;
        logic          l;
        int            cyc;
    } obs_t;

    logic             clk;
    logic             rst;
    logic [NB-1:0]    in_valid;
    logic [NB-1:0]    in_last;
    logic [NB*DW-1:0] in_data;
    logic [NB-1:0]    in_ready;
    logic [NB-1:0]    req_mask;
    logic             arb_enable;
    logic [3:0]       board_sel;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [3:0]       out_board;
    logic             out_ready;
    logic             err_oversize;
    logic [31:0]      pkt_count;

    flit_t src_q[NB][$];
    flit_t exp_q[NB][$];
    int    seg[NB];
    obs_t  log_q[$];
    int    enable_cyc[$];
    int    err_cyc[$];
    int    grant_order[$];
    logic  rdy_q[$];
    bit    rdy_rand;
    int    arb_last;
    int    cyc;
    int    checks;
    int    errors;

    board_packet_forwarder #(
        .DATA_WIDTH (DW),
        .MAX_FLITS  (MAXF),
        .CNT_WIDTH  (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid),
        .i_in_last      (in_last),
        .i_in_data      (in_data),
        .o_in_ready     (in_ready),
        .o_req_mask     (req_mask),
        .o_arb_enable   (arb_enable),
        .i_board_sel    (board_sel),
        .o_out_valid    (out_valid),
        .o_out_data     (out_data),
        .o_out_last     (out_last),
        .o_out_board    (out_board),
        .i_out_ready    (out_ready),
        .o_err_oversize (err_oversize),
        .o_pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sources, arbiter and monitor: sample at negedge, update inputs 1 time unit after posedge.
    initial begin
        logic [NB-1:0] pop;
        bit            pend;
        int            g;
        pend = 0;
        g    = 8;
        forever begin
            @(negedge clk);
            cyc++;
            pop = '0;
            if (!rst) begin
                for (int k = 0; k < NB; k++)
                    if (in_valid[k] && in_ready[k]) pop[k] = 1'b1;
                if (out_valid && out_ready)
                    log_q.push_back('{int'(out_board), out_data, out_last, cyc});
                if (err_oversize) err_cyc.push_back(cyc);
                if (arb_enable) begin
                    int start;
                    int span;
                    enable_cyc.push_back(cyc);
                    start = (arb_last == 8) ? 0 : arb_last + 1;
                    span  = (arb_last == 8) ? 8 : 7;
                    g = 8;
                    for (int i = 0; i < span; i++)
                        if (g == 8 && req_mask[(start + i) % 8]) g = (start + i) % 8;
                    arb_last = g;
                    if (g != 8) grant_order.push_back(g);
                    pend = 1;
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NB; k++)
                if (pop[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (pend) begin
                board_sel = 4'(g);
                pend      = 0;
            end
            for (int k = 0; k < NB; k++) begin
                in_valid[k] = (src_q[k].size() > 0);
                in_last[k]  = (src_q[k].size() > 0) ? src_q[k][0].l : 1'b0;
                in_data[k*DW +: DW] = (src_q[k].size() > 0) ? src_q[k][0].d : '0;
            end
            if (rdy_q.size() > 0) out_ready = rdy_q.pop_front();
            else if (rdy_rand)    out_ready = ($urandom_range(0, 3) != 0);
            else                  out_ready = 1'b1;
        end
    end

    // Source sees n flits with tail on the last; downstream expects a forced tail every MAXF flits.
    task automatic send_pkt(input int b, input int n, input bit tail);
        for (int i = 0; i < n; i++) begin
            flit_t f;
            flit_t e;
            f.d = {$urandom(), $urandom()};
            f.l = tail && (i == n - 1);
            src_q[b].push_back(f);
            seg[b]++;
            e   = f;
            e.l = f.l || (seg[b] == MAXF);
            if (e.l) seg[b] = 0;
            exp_q[b].push_back(e);
        end
    endtask

    function automatic int pending_src();
        int s = 0;
        for (int k = 0; k < NB; k++) s += src_q[k].size();
        return s;
    endfunction

    function automatic int pending_exp();
        int s = 0;
        for (int k = 0; k < NB; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic drain(input int budget, output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pending_src() == 0 && !out_valid) begin
                timed_out = 0;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        board_sel = 4'd8;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_board !== 4'd8)    begin errors++; $display("FAIL reset_out_board got=%0d exp=8", out_board); end
        checks++; if (pkt_count !== 32'd0)   begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (arb_enable !== 1'b0 || err_oversize !== 1'b0 || out_last !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl got=%0b%0b%0b exp=000", arb_enable, err_oversize, out_last); end
        checks++; if (in_ready !== 8'd0 || out_data !== '0)
            begin errors++; $display("FAIL reset_ready_data got=%0h/%0h exp=0/0", in_ready, out_data); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (arb_enable !== 1'b0 || out_board !== 4'd8)
            begin errors++; $display("FAIL reset_idle got=%0b/%0d exp=0/8", arb_enable, out_board); end
    endtask

    task automatic test_two_boards();
        logic [31:0] p0 = pkt_count;
        int l0 = log_q.size();
        int g0 = grant_order.size();
        int cur = 8;
        bit to;
        @(negedge clk);
        send_pkt(1, 2, 1);
        send_pkt(5, 2, 1);
        drain(200, to);
        checks++; if (to) begin errors++; $display("FAIL two_timeout got=stuck exp=drained"); end
        checks++; if (log_q.size() - l0 != 4) begin errors++; $display("FAIL two_count got=%0d exp=4", log_q.size() - l0); end
        if (log_q.size() - l0 == 4) begin
            checks++;
            if (log_q[l0].b != 1 || log_q[l0+1].b != 1 || log_q[l0+2].b != 5 || log_q[l0+3].b != 5)
                begin errors++; $display("FAIL two_order got=%0d%0d%0d%0d exp=1155", log_q[l0].b, log_q[l0+1].b, log_q[l0+2].b, log_q[l0+3].b); end
        end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b < 0 || o.b > 7 || exp_q[o.b].size() == 0) begin
                errors++; $display("FAIL two_unexpected got=board%0d exp=none", o.b);
            end else begin
                flit_t f = exp_q[o.b].pop_front();
                if (o.d !== f.d || o.l !== f.l || (cur != 8 && o.b != cur)) begin
                    errors++; $display("FAIL two_flit got=b%0d %0h l%0b exp=b%0d %0h l%0b", o.b, o.d, o.l, (cur == 8) ? o.b : cur, f.d, f.l);
                end
            end
            cur = o.l ? 8 : o.b;
        end
        checks++; if (grant_order.size() - g0 != 2) begin errors++; $display("FAIL two_grants got=%0d exp=2", grant_order.size() - g0); end
        checks++; if (pkt_count - p0 != 32'd2) begin errors++; $display("FAIL two_pkt_count got=%0d exp=2", pkt_count - p0); end
    endtask

    task automatic test_single();
        logic [31:0] p0 = pkt_count;
        int l0 = log_q.size();
        int e0 = enable_cyc.size();
        bit to;
        @(negedge clk);
        send_pkt(3, 4, 1);
        drain(200, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout got=stuck exp=drained"); end
        checks++; if (log_q.size() - l0 != 4) begin errors++; $display("FAIL single_count got=%0d exp=4", log_q.size() - l0); end
        if (log_q.size() - l0 == 4 && enable_cyc.size() - e0 == 1) begin
            checks++; if (log_q[l0].cyc != enable_cyc[e0] + 2)
                begin errors++; $display("FAIL single_first_latency got=%0d exp=%0d", log_q[l0].cyc - enable_cyc[e0], 2); end
            checks++; if (log_q[l0+3].cyc != enable_cyc[e0] + 5)
                begin errors++; $display("FAIL single_last_latency got=%0d exp=%0d", log_q[l0+3].cyc - enable_cyc[e0], 5); end
            for (int i = 0; i < 4; i++) begin
                flit_t f = exp_q[3].pop_front();
                checks++;
                if (log_q[l0+i].b != 3 || log_q[l0+i].d !== f.d || log_q[l0+i].l !== f.l)
                    begin errors++; $display("FAIL single_flit%0d got=b%0d %0h l%0b exp=b3 %0h l%0b", i, log_q[l0+i].b, log_q[l0+i].d, log_q[l0+i].l, f.d, f.l); end
            end
        end else begin
            checks++; errors++; $display("FAIL single_enables got=%0d exp=1", enable_cyc.size() - e0);
        end
        checks++; if (pkt_count - p0 != 32'd1) begin errors++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count - p0); end
        for (int k = 0; k < NB; k++) exp_q[k].delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] p0 = pkt_count;
        int l0 = log_q.size();
        int e0 = enable_cyc.size();
        int cur = 8;
        bit to;
        @(negedge clk);
        send_pkt(2, 3, 1);
        send_pkt(2, 3, 1);
        drain(200, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got=stuck exp=drained"); end
        checks++; if (enable_cyc.size() - e0 != 3) begin errors++; $display("FAIL b2b_rounds got=%0d exp=3", enable_cyc.size() - e0); end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b != 2 || exp_q[2].size() == 0) begin
                errors++; $display("FAIL b2b_unexpected got=board%0d exp=board2", o.b);
            end else begin
                flit_t f = exp_q[2].pop_front();
                if (o.d !== f.d || o.l !== f.l)
                    begin errors++; $display("FAIL b2b_flit got=%0h l%0b exp=%0h l%0b", o.d, o.l, f.d, f.l); end
            end
        end
        checks++; if (pending_exp() != 0) begin errors++; $display("FAIL b2b_missing got=%0d exp=0", pending_exp()); end
        checks++; if (pkt_count - p0 != 32'd2) begin errors++; $display("FAIL b2b_pkt_count got=%0d exp=2", pkt_count - p0); end
        for (int k = 0; k < NB; k++) exp_q[k].delete();
    endtask

    task automatic test_oversize();
        logic [31:0] p0 = pkt_count;
        int l0 = log_q.size();
        int r0 = err_cyc.size();
        bit to;
        @(negedge clk);
        send_pkt(0, 70, 1);
        drain(500, to);
        checks++; if (to) begin errors++; $display("FAIL over_timeout got=stuck exp=drained"); end
        checks++; if (log_q.size() - l0 != 70) begin errors++; $display("FAIL over_count got=%0d exp=70", log_q.size() - l0); end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b != 0 || exp_q[0].size() == 0) begin
                errors++; $display("FAIL over_unexpected got=board%0d exp=board0", o.b);
            end else begin
                flit_t f = exp_q[0].pop_front();
                if (o.d !== f.d || o.l !== f.l)
                    begin errors++; $display("FAIL over_flit%0d got=%0h l%0b exp=%0h l%0b", i - l0 + 1, o.d, o.l, f.d, f.l); end
            end
        end
        checks++; if (err_cyc.size() - r0 != 1) begin errors++; $display("FAIL over_err_pulses got=%0d exp=1", err_cyc.size() - r0); end
        if (err_cyc.size() - r0 == 1 && log_q.size() - l0 >= 64) begin
            checks++; if (err_cyc[r0] != log_q[l0+63].cyc + 1)
                begin errors++; $display("FAIL over_err_timing got=%0d exp=%0d", err_cyc[r0], log_q[l0+63].cyc + 1); end
        end
        checks++; if (pkt_count - p0 != 32'd2) begin errors++; $display("FAIL over_pkt_count got=%0d exp=2", pkt_count - p0); end
        for (int k = 0; k < NB; k++) exp_q[k].delete();
    endtask

    task automatic test_stall();
        logic [31:0]   p0 = pkt_count;
        int            l0 = log_q.size();
        bit            prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        int            stalls = 0;
        bit            to;
        @(negedge clk);
        send_pkt(7, 3, 1);
        rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (in_ready !== (8'(out_ready) << out_board))
                    begin errors++; $display("FAIL stall_in_ready got=%0h exp=%0h", in_ready, 8'(out_ready) << out_board); end
                if (prev_stall) begin
                    checks++;
                    if (out_data !== prev_data)
                        begin errors++; $display("FAIL stall_data_stable got=%0h exp=%0h", out_data, prev_data); end
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stalls++;
            prev_data  = out_data;
        end
        drain(100, to);
        checks++; if (to || stalls != 2) begin errors++; $display("FAIL stall_cycles got=%0d exp=2", stalls); end
        checks++; if (log_q.size() - l0 != 3) begin errors++; $display("FAIL stall_count got=%0d exp=3", log_q.size() - l0); end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b != 7 || exp_q[7].size() == 0) begin
                errors++; $display("FAIL stall_unexpected got=board%0d exp=board7", o.b);
            end else begin
                flit_t f = exp_q[7].pop_front();
                if (o.d !== f.d || o.l !== f.l)
                    begin errors++; $display("FAIL stall_flit got=%0h l%0b exp=%0h l%0b", o.d, o.l, f.d, f.l); end
            end
        end
        checks++; if (pkt_count - p0 != 32'd1) begin errors++; $display("FAIL stall_pkt_count got=%0d exp=1", pkt_count - p0); end
        for (int k = 0; k < NB; k++) exp_q[k].delete();
    endtask

    task automatic test_random();
        logic [31:0] p0 = pkt_count;
        int l0 = log_q.size();
        int cur = 8;
        bit to;
        rdy_rand = 1;
        for (int p = 0; p < 16; p++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            send_pkt($urandom_range(0, NB - 1), $urandom_range(1, 10), 1);
        end
        drain(3000, to);
        rdy_rand = 0;
        checks++; if (to) begin errors++; $display("FAIL rand_timeout got=stuck exp=drained"); end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b < 0 || o.b > 7 || exp_q[o.b].size() == 0) begin
                errors++; $display("FAIL rand_unexpected got=board%0d exp=none", o.b);
            end else begin
                flit_t f = exp_q[o.b].pop_front();
                if (o.d !== f.d || o.l !== f.l || (cur != 8 && o.b != cur))
                    begin errors++; $display("FAIL rand_flit got=b%0d %0h l%0b exp=b%0d %0h l%0b", o.b, o.d, o.l, (cur == 8) ? o.b : cur, f.d, f.l); end
            end
            cur = o.l ? 8 : o.b;
        end
        checks++; if (pending_exp() != 0) begin errors++; $display("FAIL rand_missing got=%0d exp=0", pending_exp()); end
        checks++; if (pkt_count - p0 != 32'd16) begin errors++; $display("FAIL rand_pkt_count got=%0d exp=16", pkt_count - p0); end
        for (int k = 0; k < NB; k++) exp_q[k].delete();
    endtask

    task automatic test_mid_reset();
        int  l0 = log_q.size();
        int  e0;
        bit  seen = 0;
        bit  to;
        @(negedge clk);
        send_pkt(4, 5, 1);
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (log_q.size() - l0 >= 1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mrst_first_flit got=none exp=flit1"); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_board !== 4'd8 || in_ready !== 8'd0 || arb_enable !== 1'b0)
            begin errors++; $display("FAIL mrst_outputs got=v%0b b%0d r%0h e%0b exp=v0 b8 r0 e0", out_valid, out_board, in_ready, arb_enable); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mrst_pkt_count got=%0d exp=0", pkt_count); end
        for (int k = 0; k < NB; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            seg[k] = 0;
        end
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        l0 = log_q.size();
        e0 = enable_cyc.size();
        send_pkt(6, 2, 1);
        drain(200, to);
        checks++; if (to || enable_cyc.size() - e0 != 1)
            begin errors++; $display("FAIL mrst_rearb got=%0d exp=1", enable_cyc.size() - e0); end
        checks++; if (log_q.size() - l0 != 2) begin errors++; $display("FAIL mrst_count got=%0d exp=2", log_q.size() - l0); end
        for (int i = l0; i < log_q.size(); i++) begin
            obs_t o = log_q[i];
            checks++;
            if (o.b != 6 || exp_q[6].size() == 0) begin
                errors++; $display("FAIL mrst_unexpected got=board%0d exp=board6", o.b);
            end else begin
                flit_t f = exp_q[6].pop_front();
                if (o.d !== f.d || o.l !== f.l)
                    begin errors++; $display("FAIL mrst_flit got=%0h l%0b exp=%0h l%0b", o.d, o.l, f.d, f.l); end
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL mrst_pkt_after got=%0d exp=1", pkt_count); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rdy_rand = 0;
        arb_last = 7;
        for (int k = 0; k < NB; k++) seg[k] = 0;
        test_reset();
        test_two_boards();
        test_single();
        test_back_to_back();
        test_oversize();
        test_stall();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
